bin_counter: RTL and testbench

- Parameterised N-bit universal binary counter: synchronous clear, parallel load, enable, and up/down count with wrap-around.
- Provides combinational terminal-count flags at all-ones and zero.
- General-purpose leaf block for timers, address generators and sequencers; single clock domain.

---
 rtl/bin_counter_pkg.sv | 36 +++
 rtl/bin_counter.sv | 63 ++++++
 tb/tb_bin_counter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/bin_counter_pkg.sv
// Shared types for the universal binary counter.
// Contents: default width, next-state operation encoding, and the
// priority decoder that maps the synchronous controls onto one operation.
package bin_counter_pkg;

    localparam int unsigned DEFAULT_N = 8;

    // One operation is selected per rising edge.
    typedef enum logic [2:0] {
        OP_HOLD = 3'd0,
        OP_CLR  = 3'd1,
        OP_LOAD = 3'd2,
        OP_INC  = 3'd3,
        OP_DEC  = 3'd4
    } op_e;

    // Priority: clear > load > count (direction from up) > hold.
    function automatic op_e decode_op(
        input logic syn_clr,
        input logic load,
        input logic en,
        input logic up
    );
        op_e op;
        op = OP_HOLD;
        if (syn_clr) begin
            op = OP_CLR;
        end else if (load) begin
            op = OP_LOAD;
        end else if (en) begin
            op = up ? OP_INC : OP_DEC;
        end
        return op;
    endfunction

endpackage

// File: rtl/bin_counter.sv
// N-bit universal binary counter with synchronous clear, parallel load,
// enable and up/down count with wrap-around.
// Ports:
//   clk      - clock, all state changes on the rising edge
//   rst_n    - asynchronous reset, active-high (forces q to 0 while 1)
//   syn_clr  - synchronous clear, highest synchronous priority
//   load     - synchronous parallel load of d
//   en       - count enable
//   up       - count direction, 1 = increment, 0 = decrement
//   d        - parallel load value
//   max_tick - combinational flag, q == 2^N-1
//   min_tick - combinational flag, q == 0
//   q        - current count, taken directly from the count register
module bin_counter
    import bin_counter_pkg::*;
#(
    parameter int unsigned N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         syn_clr,
    input  logic         load,
    input  logic         en,
    input  logic         up,
    input  logic [N-1:0] d,
    output logic         max_tick,
    output logic         min_tick,
    output logic [N-1:0] q
);

    logic [N-1:0] r_q;
    logic [N-1:0] w_next;
    op_e          w_op;

    // Count register; reset polarity is active-high despite the name.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_q <= '0;
        end else begin
            r_q <= w_next;
        end
    end

    // Next-state selection; N-bit arithmetic discards carry/borrow so
    // the count wraps in both directions.
    always_comb begin
        w_next = r_q;
        w_op   = decode_op(syn_clr, load, en, up);
        case (w_op)
            OP_CLR:  w_next = '0;
            OP_LOAD: w_next = d;
            OP_INC:  w_next = r_q + N'(1);
            OP_DEC:  w_next = r_q - N'(1);
            default: w_next = r_q;
        endcase
    end

    // Terminal-count flags follow the register with no added latency.
    assign max_tick = &r_q;
    assign min_tick = ~|r_q;
    assign q        = r_q;

endmodule

// File: tb/tb_bin_counter.sv
// Self-checking bench for bin_counter (N = 3): directed sequence followed by
// randomized control traffic, all checked against an arithmetic model.
module tb_bin_counter;

    localparam int unsigned N   = 3;
    localparam int          MOD = 8;
    localparam int          TOP = MOD - 1;

    logic         clk;
    logic         rst_n;
    logic         syn_clr;
    logic         load;
    logic         en;
    logic         up;
    logic [N-1:0] d;
    logic         max_tick;
    logic         min_tick;
    logic [N-1:0] q;

    int total;
    int bad;
    int exp_q;

    bin_counter #(.N(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .syn_clr  (syn_clr),
        .load     (load),
        .en       (en),
        .up       (up),
        .d        (d),
        .max_tick (max_tick),
        .min_tick (min_tick),
        .q        (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".q"},   int'(q),        exp_q);
        check({tag, ".max"}, int'(max_tick), int'(exp_q == TOP));
        check({tag, ".min"}, int'(min_tick), int'(exp_q == 0));
    endtask

    // Apply controls on the falling edge, advance the model on the rising
    // edge, then check just after it.
    task automatic step(input string tag, input logic c, input logic l,
                        input logic e, input logic u, input logic [N-1:0] dv);
        @(negedge clk);
        syn_clr = c;
        load    = l;
        en      = e;
        up      = u;
        d       = dv;
        @(posedge clk);
        if (c)      exp_q = 0;
        else if (l) exp_q = int'(dv);
        else if (e) exp_q = u ? (exp_q + 1) % MOD : (exp_q + MOD - 1) % MOD;
        #1;
        check_outputs(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total   = 0;
        bad     = 0;
        exp_q   = 0;
        rst_n   = 1'b1;
        syn_clr = 1'b0;
        load    = 1'b0;
        en      = 1'b0;
        up      = 1'b1;
        d       = '0;

        // Power-on reset.
        #12;
        check_outputs("por");
        @(negedge clk);
        rst_n = 1'b0;
        step("rel_hold", 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);

        // Asynchronous reset mid-cycle, synchronous inputs ignored meanwhile.
        step("load5", 1'b0, 1'b1, 1'b0, 1'b0, 3'd5);
        @(negedge clk);
        load = 1'b1;
        d    = 3'd6;
        en   = 1'b1;
        #2;
        rst_n = 1'b1;
        exp_q = 0;
        #1;
        check_outputs("async_rst");
        @(posedge clk);
        #1;
        check_outputs("rst_held");
        @(negedge clk);
        rst_n = 1'b0;
        load  = 1'b0;
        en    = 1'b0;
        #1;
        check_outputs("rst_rel");

        // Load then hold.
        step("load3", 1'b0, 1'b1, 1'b0, 1'b1, 3'd3);
        step("hold",  1'b0, 1'b0, 1'b0, 1'b1, 3'd7);
        step("hold",  1'b0, 1'b0, 1'b0, 1'b0, 3'd7);

        // Clear and load priority.
        step("clr_pri",  1'b1, 1'b1, 1'b1, 1'b1, 3'd6);
        step("load_pri", 1'b0, 1'b1, 1'b1, 1'b1, 3'd2);
        step("clr",      1'b1, 1'b0, 1'b0, 1'b0, 3'd0);

        // Up count with wrap, pause, resume.
        for (int i = 0; i < 10; i++) step("up", 1'b0, 1'b0, 1'b1, 1'b1, 3'd0);
        for (int i = 0; i < 2; i++)  step("pause", 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
        for (int i = 0; i < 2; i++)  step("resume", 1'b0, 1'b0, 1'b1, 1'b1, 3'd0);

        // Down count with wrap.
        for (int i = 0; i < 10; i++) step("down", 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);

        // Direction reversal: count up until the wrap to 0, then step down.
        for (int i = 0; i < 16 && (i == 0 || exp_q != 0); i++)
            step("rev_up", 1'b0, 1'b0, 1'b1, 1'b1, 3'd0);
        check("rev_at_min", int'(min_tick), 1);
        step("rev_down", 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
        check("rev_at_max", int'(max_tick), 1);

        // Randomized control traffic.
        for (int i = 0; i < 400; i++) begin
            logic c, l, e, u;
            c = ($urandom_range(0, 15) == 0);
            l = ($urandom_range(0, 9) == 0);
            e = ($urandom_range(0, 3) != 0);
            u = 1'($urandom_range(0, 1));
            step("rand", c, l, e, u, 3'($urandom_range(0, 7)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
